eep_core: RTL and testbench

Multi-cycle executing core for the EEP processor: fetches 16-bit instructions from a synchronous code memory, decodes them, executes ALU/load/store/branch operations against an internal register file, and maintains PC and condition flags. It sits below the EEP top level, which wires its instruction and data ports to the existing `rom` and `dram` instances. The core is parametrised in data width and PC width, adds a start/halt control handshake, and provides a debug read port.

---
 rtl/eep_pkg.sv | 33 +++
 rtl/eep_alu.sv | 45 ++++
 rtl/eep_core.sv | 159 +++++++++++++++
 tb/tb_eep_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eep_pkg.sv
// EEP shared declarations: opcodes, FSM states, instruction field layout, flags.
// Declarations only; no latency, no backpressure.
package eep_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM6_W  = 6;
  localparam int IMM9_W  = 9;
  localparam int IMM12_W = 12;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_LSL  = 4'h5, OP_ADDI = 4'h6, OP_MOVI = 4'h7,
    OP_LDR  = 4'h8, OP_STR  = 4'h9, OP_JMP  = 4'hA, OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC, OP_NOPD = 4'hD, OP_NOPE = 4'hE, OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
  } state_e;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

endpackage

// File: rtl/eep_alu.sv
// EEP ALU: result and Z/N/C for ops 0-6; C is carry (ADD/ADDI) or not-borrow (SUB).
// Purely combinational, zero latency; no backpressure.
module eep_alu
  import eep_pkg::*;
#(
  parameter int W = 16
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         z,
  output logic         n,
  output logic         c
);

  localparam int SH_W = $clog2(W);

  logic [W:0] sum;

  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[W-1:0];
        c   = sum[W];
      end
      OP_SUB: begin
        res = a - b;
        c   = (a >= b);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LSL:  res = a << b[SH_W-1:0];
      default: res = '0;
    endcase
    z = (res == '0);
    n = res[W-1];
  end

endmodule

// File: rtl/eep_core.sv
// EEP multi-cycle core: fetch/decode/execute against sync code and data memories.
// 3 cycles per instruction (LDR 4); no backpressure, memories answer the next cycle.
module eep_core
  import eep_pkg::*;
#(
  parameter int REG_WIDTH   = 16,
  parameter int PC_WIDTH    = 16,
  parameter int REG_DEPTH   = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_pc,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [15:0]          imem_rdata,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic                 busy,
  output logic                 halted,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic [2:0]           dbg_ad,
  output logic [REG_WIDTH-1:0] dbg_dout
);

  if (REG_DEPTH != 8) begin : g_bad_depth
    $error("eep_core: REG_DEPTH must be 8");
  end
  if (INSTR_WIDTH != INSTR_W) begin : g_bad_instr
    $error("eep_core: INSTR_WIDTH must be 16");
  end
  if (REG_WIDTH < 8) begin : g_bad_width
    $error("eep_core: REG_WIDTH must be at least 8");
  end

  typedef logic [REG_WIDTH-1:0] reg_t;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  instr_t              ir_q, ir_d;
  flags_t              flags_q, flags_d;
  reg_t                regs_q [REG_DEPTH];
  reg_t                regs_d [REG_DEPTH];

  op_e                 op;
  logic [2:0]          rd, ra, rb;
  reg_t                imm6_s, imm9_z, alu_b, alu_res, mem_addr;
  logic [PC_WIDTH-1:0] off9, off12;
  logic                alu_z, alu_n, alu_c;

  assign op       = op_e'(ir_q[OP_LSB +: 4]);
  assign rd       = ir_q[RD_LSB +: 3];
  assign ra       = ir_q[RA_LSB +: 3];
  assign rb       = ir_q[RB_LSB +: 3];
  assign imm6_s   = REG_WIDTH'($signed(ir_q[IMM6_W-1:0]));
  assign imm9_z   = REG_WIDTH'(ir_q[IMM9_W-1:0]);
  assign off9     = PC_WIDTH'($signed(ir_q[IMM9_W-1:0]));
  assign off12    = PC_WIDTH'($signed(ir_q[IMM12_W-1:0]));
  assign alu_b    = (op == OP_ADDI) ? imm6_s : regs_q[rb];
  assign mem_addr = regs_q[ra] + imm6_s;

  eep_alu #(.W(REG_WIDTH)) u_alu (
    .op  (op),
    .a   (regs_q[ra]),
    .b   (alu_b),
    .res (alu_res),
    .z   (alu_z),
    .n   (alu_n),
    .c   (alu_c)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    regs_d     = regs_q;
    imem_addr  = '0;
    dmem_addr  = '0;
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
        end
      end
      S_FETCH: begin
        imem_addr = pc_q;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_WIDTH'(1);
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_ADDI: begin
            regs_d[rd] = alu_res;
            flags_d    = {alu_z, alu_n, alu_c};
          end
          OP_MOVI: regs_d[rd] = imm9_z;
          OP_LDR: begin
            dmem_addr = mem_addr;
            state_d   = S_MEM;
            pc_d      = pc_q;
          end
          OP_STR: begin
            dmem_addr  = mem_addr;
            dmem_wdata = regs_q[rd];
            // A reset landing on this cycle must not leak a write to memory.
            dmem_we    = rst_n;
          end
          OP_JMP: pc_d = pc_q + off12;
          OP_BEQ: if (flags_q.z)  pc_d = pc_q + off9;
          OP_BNE: if (!flags_q.z) pc_d = pc_q + off9;
          OP_HALT: begin
            state_d = S_HALTED;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        regs_d[rd] = dmem_rdata;
        pc_d       = pc_q + PC_WIDTH'(1);
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted   = (state_q == S_HALTED);
  assign pc       = pc_q;
  assign dbg_dout = regs_q[dbg_ad];

endmodule

// File: tb/tb_eep_core.sv
// Self-checking bench for eep_core: ALU vector table, memory, branch, wrap and reset sequences.
// Stores are checked through an expected-store queue; results through an expected-result queue.
module tb_eep_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [15:0] start_pc, imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc, dbg_dout;
  logic        dmem_we, busy, halted;
  logic [2:0]  dbg_ad;

  logic        start9, dmem_we9, busy9, halted9;
  logic [15:0] imem_addr9, imem_rdata9, pc9;
  logic [8:0]  dmem_addr9, dmem_wdata9, dmem_rdata9, dbg_dout9;
  logic [2:0]  dbg_ad9;
  assign dmem_rdata9 = '0;

  eep_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .busy(busy), .halted(halted), .pc(pc), .dbg_ad(dbg_ad), .dbg_dout(dbg_dout)
  );

  eep_core #(.REG_WIDTH(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start9), .start_pc(16'h0000),
    .imem_addr(imem_addr9), .imem_rdata(imem_rdata9),
    .dmem_addr(dmem_addr9), .dmem_we(dmem_we9), .dmem_wdata(dmem_wdata9), .dmem_rdata(dmem_rdata9),
    .busy(busy9), .halted(halted9), .pc(pc9), .dbg_ad(dbg_ad9), .dbg_dout(dbg_dout9)
  );

  // Memory models
  logic [15:0] imem  [64];
  logic [15:0] imem9 [8];
  logic [15:0] dmem  [16];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    imem_rdata  <= imem[imem_addr[5:0]];
    imem_rdata9 <= imem9[imem_addr9[2:0]];
    dmem_rdata  <= dmem[dmem_addr[3:0]];
    if (dmem_we) begin
      dmem[dmem_addr[3:0]] <= dmem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  typedef struct packed {logic [15:0] a; logic [15:0] d;} st_t;
  st_t st_q[$];
  int  we_cnt = 0;
  st_t st_e;
  always @(negedge clk) begin
    if (dmem_we) begin
      we_cnt++;
      if (st_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_store: addr %h data %h, expected no store", dmem_addr, dmem_wdata);
      end else begin
        st_e = st_q.pop_front();
        chk("store_addr", {16'h0, dmem_addr}, {16'h0, st_e.a});
        chk("store_data", {16'h0, dmem_wdata}, {16'h0, st_e.d});
      end
    end
  end

  localparam logic [15:0] HALT = 16'hF000;

  task automatic clr_imem();
    for (int i = 0; i < 64; i++) imem[i] = HALT;
  endtask

  task automatic run(input logic [15:0] spc, input int budget, output int cyc);
    start_pc = spc;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("run_halted", {31'h0, halted}, 32'd1);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
    dbg_ad = a;
    #1 v = dbg_dout;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  lo;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [15:0] res;
    logic        z, n, c;
  } vec_t;

  localparam int NV = 12;
  vec_t        vt [NV];
  logic [18:0] exp_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, we0, wr0;
    logic [15:0] v;
    logic [18:0] e;

    // op, low6 (rb=r2 or imm6), r1, r2, result, Z, N, C
    vt[0]  = '{4'h0, 6'o20, 9'h005, 9'h003, 16'h0008, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{4'h1, 6'o20, 9'h005, 9'h003, 16'h0002, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{4'h1, 6'o20, 9'h003, 9'h005, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{4'h1, 6'o20, 9'h005, 9'h005, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{4'h2, 6'o20, 9'h1F0, 9'h0FF, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{4'h3, 6'o20, 9'h100, 9'h0FF, 16'h01FF, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{4'h4, 6'o20, 9'h1FF, 9'h0FF, 16'h0100, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{4'h5, 6'o20, 9'h1FF, 9'h007, 16'hFF80, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{4'h5, 6'o20, 9'h001, 9'h010, 16'h0001, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{4'h6, 6'h3F, 9'h001, 9'h000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[10] = '{4'h6, 6'h20, 9'h100, 9'h000, 16'h00E0, 1'b0, 1'b0, 1'b1};
    vt[11] = '{4'h0, 6'o20, 9'h1FF, 9'h1FF, 16'h03FE, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b1; start9 = 1'b0; start_pc = 16'h0010;
    dbg_ad = 3'd0; dbg_ad9 = 3'd0;
    clr_imem();
    for (int i = 0; i < 8; i++) imem9[i] = HALT;

    // Reset state, with start held high throughout
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_pc", {16'h0, pc}, 32'd0);
    chk("rst_imem_addr", {16'h0, imem_addr}, 32'd0);
    chk("rst_dmem", {15'h0, dmem_we, dmem_addr}, 32'd0);
    chk("rst_dmem_wdata", {16'h0, dmem_wdata}, 32'd0);
    chk("rst_dut9_dmem", {4'h0, dmem_we9, dmem_addr9, dmem_wdata9}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      rd_reg(r[2:0], v);
      chk($sformatf("rst_reg%0d", r), {16'h0, v}, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_after_rst", {31'h0, busy}, 32'd0);

    // ALU vector table: MOVI r1,a; MOVI r2,b; OP r3,r1,(r2|imm6); HALT
    for (int i = 0; i < NV; i++) begin
      imem[0] = {4'h7, 3'd1, vt[i].a};
      imem[1] = {4'h7, 3'd2, vt[i].b};
      imem[2] = {vt[i].op, 3'd3, 3'd1, vt[i].lo};
      imem[3] = HALT;
      exp_q.push_back({vt[i].res, vt[i].z, vt[i].n, vt[i].c});
      run(16'h0000, 40, cyc);
      chk($sformatf("alu%0d_cycles", i), cyc, 32'd12);
      rd_reg(3'd3, v);
      e = exp_q.pop_front();
      chk($sformatf("alu%0d_res_flags", i),
          {13'h0, v, dut.flags_q.z, dut.flags_q.n, dut.flags_q.c}, {13'h0, e});
    end

    // 9-bit datapath: MOVI r1,0x1FF; ADDI r1,r1,1 wraps to 0 with Z and C
    imem9[0] = {4'h7, 3'd1, 9'h1FF};
    imem9[1] = {4'h6, 3'd1, 3'd1, 6'd1};
    start9 = 1'b1;
    @(posedge clk);
    #1 start9 = 1'b0;
    cyc = 0;
    while (!halted9 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("w9_halted", {31'h0, halted9}, 32'd1);
    chk("w9_cycles", cyc, 32'd9);
    chk("w9_busy", {31'h0, busy9}, 32'd0);
    chk("w9_pc", {16'h0, pc9}, 32'd2);
    dbg_ad9 = 3'd1;
    #1 chk("w9_r1", {23'h0, dbg_dout9}, 32'd0);
    chk("w9_zc", {30'h0, dut9.flags_q.z, dut9.flags_q.c}, 32'd3);

    // Store then load back 0xBEEF through address 2
    clr_imem();
    imem[0] = {4'h7, 3'd0, 9'h000};
    imem[1] = {4'h7, 3'd1, 9'h0BE};
    imem[2] = {4'h7, 3'd2, 9'h008};
    imem[3] = {4'h5, 3'd1, 3'd1, 6'o20};
    imem[4] = {4'h7, 3'd2, 9'h0EF};
    imem[5] = {4'h3, 3'd1, 3'd1, 6'o20};
    imem[6] = {4'h9, 3'd1, 3'd0, 6'd2};
    imem[7] = {4'h8, 3'd4, 3'd0, 6'd2};
    st_q.push_back('{a: 16'h0002, d: 16'hBEEF});
    we0 = we_cnt;
    run(16'h0000, 80, cyc);
    chk("ldst_cycles", cyc, 32'd28);
    chk("ldst_we_pulses", we_cnt - we0, 32'd1);
    chk("ldst_store_seen", st_q.size(), 32'd0);
    rd_reg(3'd4, v);
    chk("ldst_r4", {16'h0, v}, 32'h0000BEEF);

    // BNE count-down loop, body runs three times
    clr_imem();
    imem[0] = {4'h7, 3'd1, 9'd3};
    imem[1] = {4'h7, 3'd2, 9'd1};
    imem[2] = {4'h7, 3'd5, 9'd0};
    imem[3] = {4'h0, 3'd5, 3'd5, 6'o20};
    imem[4] = {4'h1, 3'd1, 3'd1, 6'o20};
    imem[5] = {4'hC, 3'd0, 9'h1FE};
    run(16'h0000, 100, cyc);
    chk("bne_cycles", cyc, 32'd39);
    chk("bne_pc", {16'h0, pc}, 32'd6);
    rd_reg(3'd5, v);
    chk("bne_body_count", {16'h0, v}, 32'd3);
    rd_reg(3'd1, v);
    chk("bne_r1", {16'h0, v}, 32'd0);

    // JMP -1 from address 0 wraps the PC
    clr_imem();
    imem[0] = {4'hA, 12'hFFF};
    run(16'h0000, 40, cyc);
    chk("jmp_cycles", cyc, 32'd6);
    chk("jmp_wrap_pc", {16'h0, pc}, 32'h0000FFFF);

    // Reset during EXEC of a STR; start held high while busy and through reset
    clr_imem();
    imem[0] = {4'h7, 3'd1, 9'h055};
    imem[1] = {4'h9, 3'd1, 3'd0, 6'd5};
    we0 = we_cnt;
    wr0 = wr_cnt;
    start_pc = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1 start_pc = 16'h0030;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_ignored_pc", {16'h0, pc}, 32'd1);
    chk("str_exec_addr", {16'h0, dmem_addr}, 32'd5);
    chk("str_exec_we", {31'h0, dmem_we}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_gates_we", {31'h0, dmem_we}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_outputs", {busy, halted, dmem_we, 13'h0, pc}, 32'd0);
    chk("abort_addrs", {imem_addr, dmem_addr}, 32'd0);
    chk("abort_wdata", {16'h0, dmem_wdata}, 32'd0);
    chk("abort_no_write", wr_cnt - wr0, 32'd0);
    chk("abort_no_we", we_cnt - we0, 32'd0);
    rd_reg(3'd1, v);
    chk("abort_r1_cleared", {16'h0, v}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_beats_start", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 chk("post_abort_idle", {busy, halted}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
